// File: rtl/key_evt_pkg.sv
// Shared types for the key event queue.
// Event record, repeat FSM states, width helper.
package key_evt_pkg;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int KEV_N_KEYS = 26;
  localparam int KEV_IDX_W  = idx_width(KEV_N_KEYS);

  typedef struct packed {
    logic [KEV_IDX_W-1:0] idx;
    logic                 rpt;
  } key_evt_t;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rpt_state_t;

endpackage

// File: rtl/key_evt_fifo.sv
// First-word-fall-through FIFO of key events.
// Push is accepted when not full or when popping.
module key_evt_fifo
  import key_evt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_push,
  input  key_evt_t i_din,
  input  logic     i_pop,
  output key_evt_t o_dout,
  output logic     o_full,
  output logic     o_empty
);

  localparam int AW = idx_width(DEPTH);

  key_evt_t       r_mem [DEPTH];
  logic [AW:0]    r_wr;
  logic [AW:0]    r_rd;
  logic           w_do_pop;
  logic           w_do_push;

  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[AW] != r_rd[AW]) &&
                     (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_dout    = r_mem[r_rd[AW-1:0]];

  // Storage write; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_din;
  end

  // Read/write pointers with wrap bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + (AW+1)'(1);
      if (w_do_pop)  r_rd <= r_rd + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/key_event_queue.sv
// Key press edge detector with event queue
// and typematic auto-repeat.
module key_event_queue #(
  parameter int N_KEYS       = 26,
  parameter int IDX_W        = $clog2(N_KEYS),
  parameter int FIFO_DEPTH   = 4,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] keys,
  input  logic              repeat_en,
  input  logic              clr_ovf,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [IDX_W-1:0]  ev_idx,
  output logic              ev_repeat,
  output logic              ovf,
  output logic              any_down
);

  import key_evt_pkg::*;

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ?
                           REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = idx_width(CNT_MAX);

  logic [N_KEYS-1:0] r_prev;
  logic [N_KEYS-1:0] r_pend;
  logic              r_live;
  logic              r_ovf;
  rpt_state_t        r_state;
  logic [IDX_W-1:0]  r_trk;
  logic [CNT_W-1:0]  r_cnt;

  logic [N_KEYS-1:0] w_edge;
  logic [N_KEYS-1:0] w_clr;
  logic [N_KEYS-1:0] w_lost;
  logic              w_press_any;
  logic [IDX_W-1:0]  w_sel;
  logic              w_full;
  logic              w_empty;
  logic              w_can_push;
  logic              w_push_press;
  logic              w_push_rpt;
  logic              w_push;
  logic              w_rpt_req;
  logic              w_held;
  rpt_state_t        w_state_nxt;
  logic [IDX_W-1:0]  w_trk_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  key_evt_t          w_din;
  key_evt_t          w_head;

  assign w_edge = keys & ~r_prev;

  // Lowest-index pending press wins.
  always_comb begin
    w_press_any = 1'b0;
    w_sel       = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_press_any = 1'b1;
        w_sel       = IDX_W'(i);
      end
    end
  end

  assign w_can_push   = ~w_full | (~w_empty & ev_ready);
  assign w_push_press = w_press_any & w_can_push;
  assign w_push_rpt   = w_rpt_req & w_can_push &
                        ~w_press_any;
  assign w_push       = w_push_press | w_push_rpt;
  assign w_clr        = w_push_press ?
                        (N_KEYS'(1) << w_sel) : '0;
  assign w_lost       = w_edge & r_pend & ~w_clr;

  assign w_din.idx = w_push_press ?
                     KEV_IDX_W'(w_sel) :
                     KEV_IDX_W'(r_trk);
  assign w_din.rpt = ~w_push_press;

  // Key history, pending presses and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= '1;
      r_pend <= '0;
      r_live <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_prev <= keys;
      r_pend <= (r_pend & ~w_clr) | w_edge;
      r_live <= 1'b1;
      if (|w_lost)      r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

  assign w_held = keys[r_trk];

  // Repeat FSM: newest press takes over tracking.
  always_comb begin
    w_state_nxt = r_state;
    w_trk_nxt   = r_trk;
    w_cnt_nxt   = r_cnt;
    w_rpt_req   = 1'b0;
    if (w_push_press && repeat_en) begin
      w_trk_nxt   = w_sel;
      w_cnt_nxt   = CNT_W'(REPEAT_DELAY - 1);
      w_state_nxt = DELAY;
    end else begin
      unique case (r_state)
        IDLE: ;
        DELAY, REPEAT: begin
          if (!w_held || !repeat_en) begin
            w_state_nxt = IDLE;
          end else if (r_cnt == '0) begin
            w_rpt_req   = 1'b1;
            w_cnt_nxt   = CNT_W'(REPEAT_RATE - 1);
            w_state_nxt = REPEAT;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Repeat FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_trk   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_trk   <= w_trk_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  key_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (ev_ready),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign ev_valid  = ~w_empty;
  assign ev_idx    = ev_valid ? w_head.idx[IDX_W-1:0] : '0;
  assign ev_repeat = ev_valid & w_head.rpt;
  assign ovf       = r_ovf;
  assign any_down  = r_live & (|r_prev);

endmodule

// File: tb/tb_key_event_queue.sv
// Bench for key_event_queue: directed scenarios
// plus random stimulus against a queue-based model.
module tb_key_event_queue;

  localparam int NK    = 26;
  localparam int IW    = 5;
  localparam int DEPTH = 4;
  localparam int DLY   = 8;
  localparam int RATE  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] keys = '0;
  logic          repeat_en = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          ev_ready = 1'b0;
  logic          ev_valid;
  logic [IW-1:0] ev_idx;
  logic          ev_repeat;
  logic          ovf;
  logic          any_down;

  always #5 clk = ~clk;

  key_event_queue #(
    .N_KEYS       (NK),
    .IDX_W        (IW),
    .FIFO_DEPTH   (DEPTH),
    .REPEAT_DELAY (DLY),
    .REPEAT_RATE  (RATE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .keys      (keys),
    .repeat_en (repeat_en),
    .clr_ovf   (clr_ovf),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_idx    (ev_idx),
    .ev_repeat (ev_repeat),
    .ovf       (ovf),
    .any_down  (any_down)
  );

  // Reference model state
  logic [NK-1:0] m_prev;
  logic [NK-1:0] m_pend;
  bit            m_live;
  bit            m_ovf;
  int            q_idx[$];
  bit            q_rpt[$];
  int            m_trk;
  int            m_due;
  int            cyc = 0;
  int            n_pass = 0;
  int            n_total = 0;

  function automatic void m_reset();
    m_prev = '1;
    m_pend = '0;
    m_live = 1'b0;
    m_ovf  = 1'b0;
    q_idx.delete();
    q_rpt.delete();
    m_trk  = -1;
    m_due  = 0;
  endfunction

  // One clock edge of the model, using the inputs
  // the bench is currently driving.
  function automatic void m_step();
    logic [NK-1:0] e;
    logic [NK-1:0] lost;
    bit pop, can, pp, req, pr;
    int sel, ntrk, ndue;
    e    = keys & ~m_prev;
    pop  = ev_ready && (q_idx.size() > 0);
    can  = (q_idx.size() < DEPTH) || pop;
    sel  = -1;
    for (int i = 0; i < NK; i++)
      if (m_pend[i] && sel < 0) sel = i;
    pp   = (sel >= 0) && can;
    req  = 1'b0;
    ntrk = m_trk;
    ndue = m_due;
    if (pp && repeat_en) begin
      ntrk = sel;
      ndue = cyc + DLY;
    end else if (m_trk >= 0) begin
      if (!keys[m_trk] || !repeat_en) begin
        ntrk = -1;
      end else if (cyc == m_due) begin
        req  = 1'b1;
        ndue = cyc + RATE;
      end
    end
    pr = req && can && (sel < 0);
    if (pop) begin
      void'(q_idx.pop_front());
      void'(q_rpt.pop_front());
    end
    if (pp) begin
      q_idx.push_back(sel);
      q_rpt.push_back(1'b0);
    end else if (pr) begin
      q_idx.push_back(m_trk);
      q_rpt.push_back(1'b1);
    end
    lost = e & m_pend;
    if (pp) lost[sel] = 1'b0;
    if (|lost) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
    if (pp) m_pend[sel] = 1'b0;
    m_pend = m_pend | e;
    m_prev = keys;
    m_live = 1'b1;
    m_trk  = ntrk;
    m_due  = ndue;
  endfunction

  function automatic logic [8:0] m_out();
    logic          v;
    logic [IW-1:0] ix;
    logic          r;
    v  = (q_idx.size() > 0);
    ix = v ? IW'(q_idx[0]) : '0;
    r  = v ? q_rpt[0] : 1'b0;
    return {v, ix, r, m_ovf, m_live && (|m_prev)};
  endfunction

  function automatic logic [8:0] dut_out();
    return {ev_valid, ev_idx, ev_repeat, ovf, any_down};
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (rst_n) m_step();
    #1;
  endtask

  task automatic test_reset();
    logic [8:0] e;
    keys  = 26'h8;
    rst_n = 1'b0;
    m_reset();
    #3;
    n_total++;
    if (dut_out() !== 9'h0)
      $display("FAIL reset_state got=%h exp=%h",
               dut_out(), 9'h0);
    else n_pass++;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      e = m_out();
      n_total++;
      if (dut_out() !== e)
        $display("FAIL reset_hold c=%0d got=%h exp=%h",
                 cyc, dut_out(), e);
      else n_pass++;
    end
    n_total++;
    if (ev_valid !== 1'b0 || any_down !== 1'b1)
      $display("FAIL held_thru_reset got=%b%b exp=01",
               ev_valid, any_down);
    else n_pass++;
    keys = '0;
    for (int i = 0; i < 3; i++) tick();
    keys = 26'h8;
    tick();
    n_total++;
    if (ev_valid !== 1'b0)
      $display("FAIL press_lat1 got=%b exp=0", ev_valid);
    else n_pass++;
    tick();
    n_total++;
    if ({ev_valid, ev_idx, ev_repeat} !== {1'b1, 5'd3, 1'b0})
      $display("FAIL press_lat2 got=%b/%0d/%b exp=1/3/0",
               ev_valid, ev_idx, ev_repeat);
    else n_pass++;
    ev_ready = 1'b1;
    tick();
    n_total++;
    if (ev_valid !== 1'b0)
      $display("FAIL single_event got=%b exp=0", ev_valid);
    else n_pass++;
    keys = '0;
    tick();
    tick();
  endtask

  task automatic test_simultaneous();
    logic [8:0] e;
    int got[$];
    int first;
    first    = -1;
    ev_ready = 1'b1;
    keys     = 26'h25;
    for (int i = 1; i <= 6; i++) begin
      tick();
      e = m_out();
      n_total++;
      if (dut_out() !== e)
        $display("FAIL simul c=%0d got=%h exp=%h",
                 cyc, dut_out(), e);
      else n_pass++;
      if (ev_valid) begin
        if (first < 0) first = i;
        got.push_back(int'(ev_idx));
      end
    end
    n_total++;
    if (!(got.size() == 3 && got[0] == 0 &&
          got[1] == 2 && got[2] == 5) || first != 2)
      $display("FAIL simul_order got=%p first=%0d exp='{0,2,5} first=2",
               got, first);
    else n_pass++;
    n_total++;
    if (ovf !== 1'b0)
      $display("FAIL simul_ovf got=%b exp=0", ovf);
    else n_pass++;
    keys = '0;
    tick();
    tick();
  endtask

  task automatic test_repeat();
    logic [8:0] e;
    int at[$];
    int ix[$];
    bit rp[$];
    int exp_at[7] = '{3, 11, 15, 19, 23, 27, 31};
    bit ok;
    repeat_en = 1'b1;
    ev_ready  = 1'b1;
    keys      = '0;
    keys[7]   = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      if (i == 31) keys = '0;
      if (ev_valid && ev_ready) begin
        at.push_back(i);
        ix.push_back(int'(ev_idx));
        rp.push_back(ev_repeat);
      end
      tick();
      e = m_out();
      n_total++;
      if (dut_out() !== e)
        $display("FAIL repeat c=%0d got=%h exp=%h",
                 cyc, dut_out(), e);
      else n_pass++;
    end
    ok = (at.size() == 7);
    if (ok)
      for (int k = 0; k < 7; k++)
        if (at[k] != exp_at[k] || ix[k] != 7 ||
            rp[k] != (k != 0)) ok = 1'b0;
    n_total++;
    if (!ok)
      $display("FAIL repeat_times got=%p exp=%p",
               at, exp_at);
    else n_pass++;
    repeat_en = 1'b0;
  endtask

  task automatic test_fill();
    logic [8:0] e;
    int got[$];
    bit ok;
    ev_ready = 1'b0;
    keys     = '0;
    for (int k = 1; k <= 6; k++) begin
      keys[k] = 1'b1;
      for (int j = 0; j < 3; j++) begin
        tick();
        e = m_out();
        n_total++;
        if (dut_out() !== e)
          $display("FAIL fill c=%0d got=%h exp=%h",
                   cyc, dut_out(), e);
        else n_pass++;
      end
    end
    n_total++;
    if ({ev_valid, ev_idx, ovf} !== {1'b1, 5'd1, 1'b0})
      $display("FAIL fill_head got=%b/%0d/%b exp=1/1/0",
               ev_valid, ev_idx, ovf);
    else n_pass++;
    ev_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (ev_valid && ev_ready) got.push_back(int'(ev_idx));
      tick();
      e = m_out();
      n_total++;
      if (dut_out() !== e)
        $display("FAIL drain c=%0d got=%h exp=%h",
                 cyc, dut_out(), e);
      else n_pass++;
    end
    ok = (got.size() == 6);
    if (ok)
      for (int k = 0; k < 6; k++)
        if (got[k] != k + 1) ok = 1'b0;
    n_total++;
    if (!ok)
      $display("FAIL fill_order got=%p exp='{1,2,3,4,5,6}",
               got);
    else n_pass++;
    keys = '0;
    tick();
    tick();
  endtask

  task automatic test_ovf();
    logic [8:0] e;
    ev_ready = 1'b0;
    keys     = '0;
    for (int k = 1; k <= 4; k++) begin
      keys[k] = 1'b1;
      for (int j = 0; j < 3; j++) tick();
    end
    keys[9] = 1'b1;
    for (int j = 0; j < 3; j++) tick();
    keys[9] = 1'b0;
    tick();
    keys[9] = 1'b1;
    tick();
    n_total++;
    if (ovf !== 1'b1)
      $display("FAIL ovf_set got=%b exp=1", ovf);
    else n_pass++;
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    n_total++;
    if (ovf !== 1'b0)
      $display("FAIL ovf_clr got=%b exp=0", ovf);
    else n_pass++;
    ev_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      e = m_out();
      n_total++;
      if (dut_out() !== e)
        $display("FAIL ovf_drain c=%0d got=%h exp=%h",
                 cyc, dut_out(), e);
      else n_pass++;
    end
    keys = '0;
    tick();
    tick();
  endtask

  task automatic test_switch();
    logic [8:0] e;
    int n4, first10r, first10p;
    n4        = 0;
    first10r  = -1;
    first10p  = -1;
    repeat_en = 1'b1;
    ev_ready  = 1'b1;
    keys      = '0;
    keys[4]   = 1'b1;
    for (int i = 1; i <= 14; i++) tick();
    keys[10] = 1'b1;
    for (int j = 1; j <= 24; j++) begin
      if (ev_valid && ev_ready) begin
        if (ev_idx == 5'd4 && j > 1) n4++;
        if (ev_idx == 5'd10 && !ev_repeat &&
            first10p < 0) first10p = j;
        if (ev_idx == 5'd10 && ev_repeat &&
            first10r < 0) first10r = j;
      end
      tick();
      e = m_out();
      n_total++;
      if (dut_out() !== e)
        $display("FAIL switch c=%0d got=%h exp=%h",
                 cyc, dut_out(), e);
      else n_pass++;
    end
    n_total++;
    if (n4 != 0 || first10p != 3 || first10r != 11)
      $display("FAIL switch_track got=%0d/%0d/%0d exp=0/3/11",
               n4, first10p, first10r);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    n_total++;
    if ({ev_valid, ovf, any_down} !== 3'b000)
      $display("FAIL mid_reset got=%b exp=000",
               {ev_valid, ovf, any_down});
    else n_pass++;
    tick();
    rst_n     = 1'b1;
    keys      = '0;
    repeat_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      e = m_out();
      n_total++;
      if (dut_out() !== e)
        $display("FAIL post_reset c=%0d got=%h exp=%h",
                 cyc, dut_out(), e);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [8:0] e;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) < 3)
        keys[$urandom_range(0, NK - 1)] ^= 1'b1;
      if ((i / 50) % 3 == 2)
        ev_ready = ($urandom_range(0, 7) == 0);
      else
        ev_ready = ($urandom_range(0, 3) != 0);
      repeat_en = ((i / 120) % 2 == 0) ?
                  1'b1 : ($urandom_range(0, 15) == 0);
      clr_ovf   = ($urandom_range(0, 19) == 0);
      tick();
      e = m_out();
      n_total++;
      if (dut_out() !== e)
        $display("FAIL random c=%0d got=%h exp=%h",
                 cyc, dut_out(), e);
      else n_pass++;
    end
    clr_ovf = 1'b0;
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_repeat();
    test_fill();
    test_ovf();
    test_switch();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
